// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch address generator with stall/branch/flush redirects.
// Optional PC_ALIGN_CHECK_EN: misaligned targets redirect to EXC_VEC.
module pc_gen #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          INC       = 4,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              branch_pending,
  output logic              align_err
);

`ifdef PC_ALIGN_CHECK_EN
  localparam bit L_CHK = 1'b1;
`else
  localparam bit L_CHK = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] L_RST = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] L_EXC = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] L_INC = ADDR_W'(INC);

  typedef enum logic [1:0] {
    S_OFF,
    S_RUN,
    S_HOLD
  } st_t;

  st_t               st;
  st_t               w_st_nxt;
  logic [ADDR_W-1:0] r_ptgt;
  logic [ADDR_W-1:0] w_ptgt_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_tgt_fix;
  logic              w_pend_nxt;
  logic              w_aerr_nxt;
  logic              w_mis;

  // Target that would be taken if this edge redirects
  always_comb begin
    w_tgt = r_ptgt;
    if (flush) begin
      w_tgt = flush_pc;
    end else if (branch_valid) begin
      w_tgt = branch_target;
    end
    w_mis     = L_CHK && (w_tgt[1:0] != 2'b00);
    w_tgt_fix = w_mis ? L_EXC : w_tgt;
  end

  always_comb begin
    w_st_nxt   = st;
    w_pc_nxt   = pc;
    w_ptgt_nxt = r_ptgt;
    w_pend_nxt = branch_pending;
    w_aerr_nxt = 1'b0;
    ce         = 1'b0;
    unique case (st)
      S_OFF: begin
        w_st_nxt = S_RUN;
      end
      S_RUN, S_HOLD: begin
        ce       = 1'b1;
        w_st_nxt = (stall && !flush) ? S_HOLD : S_RUN;
        if (flush) begin
          w_pc_nxt   = w_tgt_fix;
          w_pend_nxt = 1'b0;
          w_aerr_nxt = w_mis;
        end else if (stall) begin
          if (branch_valid) begin
            w_ptgt_nxt = branch_target;
            w_pend_nxt = 1'b1;
          end
        end else if (branch_valid || branch_pending) begin
          w_pc_nxt   = w_tgt_fix;
          w_pend_nxt = 1'b0;
          w_aerr_nxt = w_mis;
        end else begin
          w_pc_nxt = pc + L_INC;
        end
      end
      default: begin
        w_st_nxt = S_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= S_OFF;
      pc             <= L_RST;
      r_ptgt         <= '0;
      branch_pending <= 1'b0;
      align_err      <= 1'b0;
    end else begin
      st             <= w_st_nxt;
      pc             <= w_pc_nxt;
      r_ptgt         <= w_ptgt_nxt;
      branch_pending <= w_pend_nxt;
      align_err      <= w_aerr_nxt;
    end
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator for the OpenMIPS IF stage.
- Produces the instruction address `pc` and the instruction-ROM chip enable `ce`.
- Handles pipeline stalls, branch redirects from ID, and exception/flush redirects from CTRL.
- Holds a branch that arrives during a stall as pending and applies it once the stall releases.

Parameters:
- ADDR_W, 32: width of pc and of all target buses.
- RESET_VEC, 32'h00000000: pc value after reset; truncated to ADDR_W.
- INC, 4: sequential increment in bytes.
- EXC_VEC, 32'h00000020: redirect vector on misaligned target. Used only with PC_ALIGN_CHECK_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  IF stall request from CTRL; pc holds while high.
- flush  in  1  exception/eret redirect; highest priority.
- flush_pc  in  ADDR_W  flush target.
- branch_valid  in  1  single-cycle branch/jump redirect from ID.
- branch_target  in  ADDR_W  branch destination.
- pc  out  ADDR_W  current fetch address.
- ce  out  1  instruction ROM enable; 1 = fetch valid.
- branch_pending  out  1  a branch is captured and waiting for the stall to release.
- align_err  out  1  misaligned-target pulse. Tied 0 without the optional feature.

Behaviour:
- State machine, state register `st`:
  - OFF: ce=0. The next edge goes to RUN.
  - RUN: ce=1, pc advances or redirects. Goes to HOLD when stall=1 and flush=0.
  - HOLD: ce=1, pc frozen. Returns to RUN when stall=0 or flush=1.
- Reset (rst=1 at an edge) forces: st=OFF, ce=0, pc=RESET_VEC, branch_pending=0, pending target=0, align_err=0.
  - Reset asserted mid-operation discards any pending branch.
- First edge after rst falls: ce goes 1 and pc stays RESET_VEC. RESET_VEC is therefore presented for exactly one fetch before the first update.
- In OFF, every input except rst is ignored.
- Next-pc update while ce=1, in strict priority order:
  1. flush=1: pc<=flush_pc; clear pending; go to RUN. Applies even if stall=1 or branch_valid=1.
  2. stall=1: pc holds. If branch_valid=1, capture branch_target into the pending register and set branch_pending=1. A later branch_valid during the same stall overwrites the pending target; the latest one wins.
  3. branch_valid=1 (no stall): pc<=branch_target; clear pending. A live branch beats an older pending one.
  4. branch_pending=1: pc<=pending target; clear pending.
  5. Otherwise: pc<=pc+INC, modulo 2^ADDR_W. The wrap from the top address to 0 is silent.
- Latency: one cycle from branch_valid or flush to the new pc. A pending branch is applied on the first edge with stall=0.
- ce never deasserts except through rst.
- branch_pending is a registered view of the pending flag.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Any flush_pc or branch_target accepted at priority 1, 3 or 4 with a nonzero value in bits [1:0] is replaced by EXC_VEC.
  - align_err pulses high for exactly the one cycle after that edge.
  - A misaligned target captured during a stall is checked when it is applied, not when it is captured.
- When undefined: targets load unmodified and align_err is constant 0.

Test Plan:
- Reset then run: hold rst 3 cycles, release.
  - Required: ce=0 and pc=0 during reset.
  - Then ce=1 with pc=0x00 for one cycle, followed by 0x04, 0x08, 0x0C on successive cycles.
- Stall hold: with pc=0x10, assert stall for 3 cycles.
  - Required: pc stays 0x10 for all 3 cycles, then 0x14 on the first cycle after release.
- Branch during stall: with pc=0x20, stall=1; branch_valid pulses with target 0x100, then again with 0x200, both inside the stall.
  - Required: branch_pending=1 and pc=0x20 throughout the stall.
  - After release: pc=0x200, branch_pending=0, then 0x204.
- Flush beats all: assert stall=1, branch_valid=1 (0x300) and flush=1 (flush_pc 0x80) in the same cycle.
  - Required: next pc=0x80, branch_pending=0.
- Wrap and reset mid-stall:
  - With ADDR_W=8 and pc=0xFC, run one cycle. Required: pc=0x00.
  - Then capture a pending branch and assert rst. Required: pc=RESET_VEC, ce=0, branch_pending=0.
- With PC_ALIGN_CHECK_EN defined: branch_valid with target 0x102.
  - Required: pc=0x20 (EXC_VEC), align_err=1 for one cycle.
  - Without the macro: pc=0x102 and align_err=0.
